matmul_job_ctrl: RTL and testbench

//  Job sequencer for one matrix-multiply pass through the mat_pad front-end and
//  the systolic array. Accepts a job (N/K/M dims) over a valid/ready handshake.

---
 rtl/matmul_job_ctrl_if.sv | 36 +++
 rtl/matmul_job_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_matmul_job_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_job_ctrl_if.sv
// Job/padder/array/result signal bundle for matmul_job_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface matmul_job_ctrl_if #(
    parameter int CW = 16
);
    logic          job_valid_i;
    logic          job_ready_o;
    logic [1:0]    N_i;
    logic [1:0]    K_i;
    logic [1:0]    M_i;
    logic          abort_i;
    logic [1:0]    N_o;
    logic [1:0]    K_o;
    logic [1:0]    M_o;
    logic          pad_start_o;
    logic          pad_done_i;
    logic          sa_clear_o;
    logic          sa_en_o;
    logic          res_valid_o;
    logic          res_ready_i;
    logic          busy_o;
    logic          err_o;
    logic [CW-1:0] cycles_o;

    modport slave (
        input  job_valid_i, N_i, K_i, M_i, abort_i, pad_done_i, res_ready_i,
        output job_ready_o, N_o, K_o, M_o, pad_start_o, sa_clear_o, sa_en_o,
               res_valid_o, busy_o, err_o, cycles_o
    );

    modport master (
        output job_valid_i, N_i, K_i, M_i, abort_i, pad_done_i, res_ready_i,
        input  job_ready_o, N_o, K_o, M_o, pad_start_o, sa_clear_o, sa_en_o,
               res_valid_o, busy_o, err_o, cycles_o
    );
endinterface

// File: rtl/matmul_job_ctrl.sv
// Job sequencer for one matrix-multiply pass (padder front-end + systolic array).
// Optional interrupt output enabled by defining MATMUL_JOB_CTRL_IRQ_EN.
module matmul_job_ctrl #(
    parameter int MAX_DIM   = 4,
    parameter int DRAIN_CYC = 7,
    parameter int TIMEOUT   = 64,
    parameter int CW        = 16
) (
    input  logic clk_i,
    input  logic reset_ni,
`ifdef MATMUL_JOB_CTRL_IRQ_EN
    input  logic irq_clr_i,
    output logic irq_o,
`endif
    matmul_job_ctrl_if.slave bus
);

    localparam int DW     = $clog2(MAX_DIM);
    localparam int CNTMAX = (TIMEOUT > DRAIN_CYC) ? TIMEOUT : DRAIN_CYC;
    localparam int CNTW   = $clog2(CNTMAX);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        DRAIN   = 3'd3,
        RESULT  = 3'd4,
        RELEASE = 3'd5,
        ERR     = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]   cycles_q, cycles_d;
    logic            job_ready_q, job_ready_d;
    logic            busy_q, busy_d;
    logic            sa_clear_q, sa_clear_d;
    logic            pad_start_q, pad_start_d;
    logic            sa_en_q, sa_en_d;
    logic            res_valid_q, res_valid_d;
    logic            err_q, err_d;
    logic            accept;

    assign accept = (state_q == IDLE) && bus.job_valid_i && job_ready_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; one down-counter serves both the RUN watchdog and
    // the DRAIN wait, reloaded whenever a new state is entered.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = CLEAR;
            end
            CLEAR: begin
                state_d = RUN;
            end
            RUN: begin
                if (bus.pad_done_i)  state_d = DRAIN;
                else if (cnt_q == '0) state_d = ERR;
                else                 cnt_d   = cnt_q - CNTW'(1);
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = RESULT;
                else             cnt_d   = cnt_q - CNTW'(1);
            end
            RESULT: begin
                if (bus.res_ready_i) state_d = RELEASE;
            end
            RELEASE: begin
                if (!bus.pad_done_i) state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.abort_i && (state_q != IDLE)) state_d = IDLE;

        if (state_d != state_q) begin
            unique case (state_d)
                RUN:     cnt_d = CNTW'(TIMEOUT - 1);
                DRAIN:   cnt_d = CNTW'(DRAIN_CYC - 1);
                default: cnt_d = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode from next state, so registered outputs move with state
    // ------------------------------------------------------------------
    always_comb begin
        job_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        sa_clear_d  = (state_d == CLEAR);
        pad_start_d = (state_d == RUN);
        sa_en_d     = (state_d == RUN) || (state_d == DRAIN);
        res_valid_d = (state_d == RESULT);

        err_d = err_q;
        if (accept)                err_d = 1'b0;
        else if (state_d == ERR)   err_d = 1'b1;

        // Counts the cycles spent in CLEAR/RUN/DRAIN; an abort freezes it.
        cycles_d = cycles_q;
        if (accept) begin
            cycles_d = '0;
        end else if (((state_q == CLEAR) || (state_q == RUN) || (state_q == DRAIN))
                     && (state_d != IDLE) && (cycles_q != {CW{1'b1}})) begin
            cycles_d = cycles_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            sa_clear_q  <= 1'b0;
            pad_start_q <= 1'b0;
            sa_en_q     <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            cycles_q    <= '0;
        end else begin
            job_ready_q <= job_ready_d;
            busy_q      <= busy_d;
            sa_clear_q  <= sa_clear_d;
            pad_start_q <= pad_start_d;
            sa_en_q     <= sa_en_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            cycles_q    <= cycles_d;
        end
    end

    // ------------------------------------------------------------------
    // Dimension latches: sampled only at acceptance, held for the job
    // ------------------------------------------------------------------
    logic [DW-1:0] dim_in [3];
    logic [DW-1:0] dim_q  [3];
    logic [DW-1:0] dim_d  [3];

    assign dim_in[0] = bus.N_i;
    assign dim_in[1] = bus.K_i;
    assign dim_in[2] = bus.M_i;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dim
            always_comb begin
                dim_d[gi] = accept ? dim_in[gi] : dim_q[gi];
            end

            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) dim_q[gi] <= '0;
                else           dim_q[gi] <= dim_d[gi];
            end
        end
    endgenerate

`ifdef MATMUL_JOB_CTRL_IRQ_EN
    logic irq_q, irq_d;
    logic irq_set;

    assign irq_set = ((state_d == RESULT) && (state_q != RESULT)) ||
                     ((state_d == ERR)    && (state_q != ERR));

    // A set in the same cycle as a clear wins.
    always_comb begin
        irq_d = irq_q;
        if (irq_clr_i) irq_d = 1'b0;
        if (irq_set)   irq_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) irq_q <= 1'b0;
        else           irq_q <= irq_d;
    end

    assign irq_o = irq_q;
`endif

    assign bus.job_ready_o = job_ready_q;
    assign bus.busy_o      = busy_q;
    assign bus.sa_clear_o  = sa_clear_q;
    assign bus.pad_start_o = pad_start_q;
    assign bus.sa_en_o     = sa_en_q;
    assign bus.res_valid_o = res_valid_q;
    assign bus.err_o       = err_q;
    assign bus.cycles_o    = cycles_q;
    assign bus.N_o         = dim_q[0];
    assign bus.K_o         = dim_q[1];
    assign bus.M_o         = dim_q[2];

endmodule

// File: tb/tb_matmul_job_ctrl.sv
// Directed bench for matmul_job_ctrl: a per-cycle vector table for one full job,
// then hand-written sequences for result hold, watchdog, abort and dim stability.
module tb_matmul_job_ctrl;

    localparam int CW = 6;   // narrow so the watchdog job saturates cycles_o

    logic clk_i = 1'b0;
    logic reset_ni = 1'b0;
`ifdef MATMUL_JOB_CTRL_IRQ_EN
    logic irq_clr_i = 1'b0;
    logic irq_o;
`endif

    always #5 clk_i = ~clk_i;

    matmul_job_ctrl_if #(.CW(CW)) bus ();

    matmul_job_ctrl #(
        .MAX_DIM(4), .DRAIN_CYC(7), .TIMEOUT(64), .CW(CW)
    ) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
`ifdef MATMUL_JOB_CTRL_IRQ_EN
        .irq_clr_i(irq_clr_i),
        .irq_o    (irq_o),
`endif
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       jv;
        logic [1:0] n, k, m;
        logic       pd, rr, ab;
        logic       e_jr, e_busy, e_clr, e_ps, e_en, e_rv;
        logic [5:0] e_cyc;
    } vec_t;

    vec_t vec [15];

    function automatic vec_t mkv(logic jv, logic [1:0] n, logic [1:0] k, logic [1:0] m,
                                 logic pd, logic rr, logic ab,
                                 logic jr, logic busy, logic clr, logic ps, logic en,
                                 logic rv, logic [5:0] cyc);
        vec_t v;
        v.jv = jv; v.n = n; v.k = k; v.m = m; v.pd = pd; v.rr = rr; v.ab = ab;
        v.e_jr = jr; v.e_busy = busy; v.e_clr = clr; v.e_ps = ps; v.e_en = en;
        v.e_rv = rv; v.e_cyc = cyc;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_st(string tag, logic jr, logic busy, logic clr, logic ps,
                          logic en, logic rv);
        chk({tag, ".job_ready"}, bus.job_ready_o, jr);
        chk({tag, ".busy"},      bus.busy_o,      busy);
        chk({tag, ".sa_clear"},  bus.sa_clear_o,  clr);
        chk({tag, ".pad_start"}, bus.pad_start_o, ps);
        chk({tag, ".sa_en"},     bus.sa_en_o,     en);
        chk({tag, ".res_valid"}, bus.res_valid_o, rv);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic accept(logic [1:0] n, logic [1:0] k, logic [1:0] m);
        bus.job_valid_i = 1'b1;
        bus.N_i = n; bus.K_i = k; bus.M_i = m;
        step();
        bus.job_valid_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

    initial begin
        int n;
        logic [CW-1:0] cyc_snap;

        bus.job_valid_i = 0; bus.N_i = 0; bus.K_i = 0; bus.M_i = 0;
        bus.abort_i = 0; bus.pad_done_i = 0; bus.res_ready_i = 0;

        // ---------------- reset state ----------------
        repeat (2) step();
        chk_st("reset", 1, 0, 0, 0, 0, 0);
        chk("reset.err", bus.err_o, 0);
        chk("reset.cycles", bus.cycles_o, 0);
        chk("reset.dims", {bus.N_o, bus.K_o, bus.M_o}, 0);
`ifdef MATMUL_JOB_CTRL_IRQ_EN
        chk("reset.irq", irq_o, 0);
`endif
        reset_ni = 1'b1;
        step();

        // ---------------- test 1: full job via vector table ----------------
        //                jv n k m  pd rr ab  jr bsy clr ps en rv cyc
        vec[0]  = mkv(1, 3, 3, 3, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0);
        vec[1]  = mkv(0, 3, 3, 3, 0, 0, 0,  0, 1, 0, 1, 1, 0, 1);
        vec[2]  = mkv(0, 3, 3, 3, 0, 0, 0,  0, 1, 0, 1, 1, 0, 2);
        vec[3]  = mkv(0, 3, 3, 3, 1, 0, 0,  0, 1, 0, 0, 1, 0, 3);
        for (int i = 4; i <= 9; i++)
            vec[i] = mkv(0, 3, 3, 3, 1, 0, 0,  0, 1, 0, 0, 1, 0, 6'(i));
        vec[10] = mkv(0, 3, 3, 3, 1, 0, 0,  0, 1, 0, 0, 0, 1, 10);
        vec[11] = mkv(0, 3, 3, 3, 1, 1, 0,  0, 1, 0, 0, 0, 0, 10);
        vec[12] = mkv(0, 3, 3, 3, 1, 0, 0,  0, 1, 0, 0, 0, 0, 10);
        vec[13] = mkv(0, 3, 3, 3, 0, 0, 0,  1, 0, 0, 0, 0, 0, 10);
        vec[14] = mkv(0, 3, 3, 3, 0, 0, 0,  1, 0, 0, 0, 0, 0, 10);

        for (int i = 0; i < 15; i++) begin
            bus.job_valid_i = vec[i].jv;
            bus.N_i = vec[i].n; bus.K_i = vec[i].k; bus.M_i = vec[i].m;
            bus.pad_done_i = vec[i].pd; bus.res_ready_i = vec[i].rr;
            bus.abort_i = vec[i].ab;
            step();
            chk_st($sformatf("t1.v%0d", i), vec[i].e_jr, vec[i].e_busy, vec[i].e_clr,
                   vec[i].e_ps, vec[i].e_en, vec[i].e_rv);
            chk($sformatf("t1.v%0d.cycles", i), bus.cycles_o, vec[i].e_cyc);
            $display("t1 vector %0d applied", i);
        end
        chk("t1.dims", {bus.N_o, bus.K_o, bus.M_o}, 6'b11_11_11);
        chk("t1.err", bus.err_o, 0);

        // ---------------- test 2: 1x2x3, result held by consumer ----------------
        accept(0, 1, 2);
        step(); step();
        bus.pad_done_i = 1;
        step();
`ifdef MATMUL_JOB_CTRL_IRQ_EN
        irq_clr_i = 1;   // clear held across RESULT entry: the set must win
`endif
        n = 0;
        while (!bus.res_valid_o && n < 20) begin
            step();
            n++;
        end
        chk("t2.drain_len", n, 7);
        chk("t2.cycles", bus.cycles_o, 10);
        chk("t2.dims", {bus.N_o, bus.K_o, bus.M_o}, 6'b00_01_10);
`ifdef MATMUL_JOB_CTRL_IRQ_EN
        chk("t2.irq_set_wins", irq_o, 1);
        irq_clr_i = 0;
`endif
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t2.hold%0d.res_valid", i), bus.res_valid_o, 1);
            chk($sformatf("t2.hold%0d.cycles", i), bus.cycles_o, 10);
`ifdef MATMUL_JOB_CTRL_IRQ_EN
            chk($sformatf("t2.hold%0d.irq", i), irq_o, 1);
`endif
        end
        bus.res_ready_i = 1;
        step();
        bus.res_ready_i = 0;
        chk_st("t2.release", 0, 1, 0, 0, 0, 0);
        step(); step();
        chk("t2.release_wait.busy", bus.busy_o, 1);
        bus.pad_done_i = 0;
        step();
        chk_st("t2.idle", 1, 0, 0, 0, 0, 0);
        $display("t2 result-hold sequence done");
`ifdef MATMUL_JOB_CTRL_IRQ_EN
        irq_clr_i = 1;
        step();
        irq_clr_i = 0;
        chk("t2.irq_clr", irq_o, 0);
`endif

        // ---------------- test 3: watchdog ----------------
        accept(1, 1, 1);
        step();
        n = 0;
        while (!bus.err_o && n < 100) begin
            step();
            n++;
        end
        chk("t3.timeout_len", n, 64);
        chk("t3.cycles_sat", bus.cycles_o, 63);
        chk("t3.pad_start", bus.pad_start_o, 0);
`ifdef MATMUL_JOB_CTRL_IRQ_EN
        chk("t3.irq", irq_o, 1);
`endif
        step();
        chk_st("t3.idle", 1, 0, 0, 0, 0, 0);
        chk("t3.err_sticky", bus.err_o, 1);
        step();
        chk("t3.err_sticky2", bus.err_o, 1);
        accept(2, 1, 0);
        chk("t3.err_cleared", bus.err_o, 0);
        chk("t3.new_cycles", bus.cycles_o, 0);
        $display("t3 watchdog sequence done");

        // pad_done on the cycle the watchdog expires: DRAIN, not ERR
        step();
        repeat (63) step();
        chk("t3b.still_run", bus.pad_start_o, 1);
        bus.pad_done_i = 1;
        step();
        chk_st("t3b.drain", 0, 1, 0, 0, 1, 0);
        chk("t3b.no_err", bus.err_o, 0);
        bus.abort_i = 1;
        step();
        bus.abort_i = 0;
        bus.pad_done_i = 0;
        chk_st("t3b.abort_idle", 1, 0, 0, 0, 0, 0);
        $display("t3b watchdog/pad_done race done");

        // ---------------- test 4: abort in RUN, abort ignored in IDLE ----------------
        bus.abort_i = 1;
        accept(2, 2, 2);
        bus.abort_i = 0;
        chk("t4.accept_with_abort", bus.sa_clear_o, 1);
        step(); step(); step();
        cyc_snap = bus.cycles_o;
        chk("t4.cycles_before", cyc_snap, 3);
        bus.abort_i = 1;
        step();
        bus.abort_i = 0;
        chk_st("t4.abort", 1, 0, 0, 0, 0, 0);
        chk("t4.cycles_frozen", bus.cycles_o, 3);
        step();
        chk("t4.cycles_frozen2", bus.cycles_o, 3);
        accept(1, 2, 3);
        chk_st("t4.reaccept", 0, 1, 1, 0, 0, 0);
        $display("t4 abort sequence done");

        // ---------------- test 5: inputs changed mid-job ----------------
        step();
        bus.job_valid_i = 1;
        bus.N_i = 0; bus.K_i = 0; bus.M_i = 0;
        step();
        bus.job_valid_i = 0;
        chk("t5.dims", {bus.N_o, bus.K_o, bus.M_o}, 6'b01_10_11);
        chk_st("t5.run", 0, 1, 0, 1, 1, 0);
        step();
        chk("t5.no_new_job", bus.sa_clear_o, 0);
        bus.pad_done_i = 1;
        step();
        n = 0;
        while (!bus.res_valid_o && n < 20) begin
            step();
            n++;
        end
        chk("t5.drain_len", n, 7);
        // abort coinciding with res_ready: abort wins, result consumed
        bus.abort_i = 1;
        bus.res_ready_i = 1;
        step();
        bus.abort_i = 0;
        bus.res_ready_i = 0;
        bus.pad_done_i = 0;
        chk_st("t5.abort_result", 1, 0, 0, 0, 0, 0);
        chk("t5.err", bus.err_o, 0);
        $display("t5 mid-job input change done");

        // ---------------- reset mid-job ----------------
        accept(3, 0, 1);
        step();
        #2 reset_ni = 1'b0;
        #1;
        chk_st("rst_mid", 1, 0, 0, 0, 0, 0);
        chk("rst_mid.dims", {bus.N_o, bus.K_o, bus.M_o}, 0);
        chk("rst_mid.cycles", bus.cycles_o, 0);
        step();
        reset_ni = 1'b1;
        step();
        chk_st("rst_after", 1, 0, 0, 0, 0, 0);
        $display("reset mid-job done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
